mod_updown_counter: RTL and testbench
=====================================

# mod_updown_counter

Parametrised successor to the team's free-running 32-bit up-counter. Adds configurable width and modulus, up/down direction, enable, synchronous clear, parallel load, and wrap or saturate at the limits. Provides a terminal-count output and a registered rollover event for cascading and for timer/prescaler use. Single clock domain; sits beside the existing counters in the basic-blocks library.

## Interface
- WIDTH, 8: counter width in bits; legal range 2–32.
- MAX_VAL, 2**WIDTH-1: upper count limit; the count range is 0..MAX_VAL; legal range 1..2**WIDTH-1.
- SATURATE, 0: 0 = wrap at the limits; 1 = hold at the limits.
- RST_VAL, 0: value loaded by reset and by clear; must be ≤ MAX_VAL (elaboration error otherwise).

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high; highest priority.
- en  in  1  count enable; one step per clock while high.
- up_dn  in  1  direction; 1 = up, 0 = down; sampled only when en=1.
- clear  in  1  synchronous clear to RST_VAL.
- load  in  1  synchronous parallel load.
- load_val  in  WIDTH  load data.
- count  out  WIDTH  registered count value.
- tc  out  1  terminal count; combinational.
- roll  out  1  registered one-cycle rollover/limit pulse.
- sat_hit  out  1  sticky flag; set when saturation blocks a step.

## Operation
- The following priority applies each rising edge:
  1. rst
  2. clear
  3. load
  4. en
  5. hold
- **rst:** count=RST_VAL, roll=0, sat_hit=0.
- **clear:** count=RST_VAL, roll=0, sat_hit=0.
- **load:**
  - count=min(load_val, MAX_VAL); out-of-range values clamp, they do not wrap.
  - roll=0; sat_hit is unchanged.
  - en is ignored that cycle.
- **en=1, up_dn=1:**
  - count<MAX_VAL: count+1.
  - count=MAX_VAL, SATURATE=0: count=0, roll=1.
  - count=MAX_VAL, SATURATE=1: count holds, roll=1, sat_hit=1.
- **en=1, up_dn=0:**
  - count>0: count-1.
  - count=0, SATURATE=0: count=MAX_VAL, roll=1.
  - count=0, SATURATE=1: count holds, roll=1, sat_hit=1.
- **en=0:** count holds, roll=0.
- **tc:** tc = en & ((up_dn & count==MAX_VAL) | (~up_dn & count==0)).
  - Cascading rule: a downstream stage's en is driven by the upstream tc.
- **Arithmetic:** compare against MAX_VAL explicitly.
  - With MAX_VAL < 2**WIDTH-1, the value MAX_VAL+1 never appears on count.
  - No intermediate overflow at WIDTH bits: the increment is never applied when count=MAX_VAL.
- **sat_hit:** cleared only by rst or clear; never set when SATURATE=0.

## Timing
- Count latency: 1 cycle from en/load/clear/rst sampled high to the new count visible.
- roll is asserted in the cycle after the limit step (aligned with the new count), and is high for exactly one cycle per limit event.
  - If en is held at the limit in saturate mode, roll pulses every cycle.
- tc has zero latency (combinational from en, up_dn and the count register). No combinational path exists from load, clear or load_val to tc.
- A direction change takes effect on the same edge it is sampled. Reversing at the limit (e.g. count=MAX_VAL, up_dn=0) is a normal step (MAX_VAL-1), with no roll.
- Reset mid-count: the next edge yields RST_VAL regardless of en, load or clear.
- All outputs are registered except tc.

## Test plan
- **Reset/clear:** WIDTH=8, RST_VAL=5, run up to 20, assert clear for one cycle.
  - Required: count=5 on the next edge, roll=0, sat_hit=0.
  - Then assert rst with load=1 and load_val=99: count=5.
- **Modulo wrap up:** WIDTH=4, MAX_VAL=9, SATURATE=0, en=1, up_dn=1 from 0.
  - Required: count 0..9,0,1; tc high only while count=9; roll high only in the cycle count=0 after 9; 10 never appears.
- **Wrap down:** same config, load 1, then en=1, up_dn=0.
  - Required: count 1,0,9,8; roll asserted with count=9.
- **Saturate:** WIDTH=8, SATURATE=1, load 254, en=1, up_dn=1 for 4 cycles.
  - Required: count 255,255,255,255; roll high on cycles 2–4; sat_hit=1 and sticky after en drops.
  - Then up_dn=0: count=254, sat_hit remains 1 until clear.
- **Load priority/clamp:** MAX_VAL=9, load=1, load_val=15, en=1 in the same cycle.
  - Required: count=9, no increment.
  - Then load=1, clear=1: count=RST_VAL.
- **Cascade:** two instances (WIDTH=4, MAX_VAL=9); the high stage's en is driven by the low stage's tc; count up for 100 cycles from 00.
  - Required: {high,low}=00 after 100 cycles with a single roll on high; at cycle 37 the value is 3,7.

Source files
------------

// File: rtl/mod_updown_counter.sv
// mod_updown_counter: parametrised up/down counter with modulus, enable, clear,
// clamping load, wrap or saturate at the limits, terminal count and rollover pulse.
module mod_updown_counter #(
   parameter int               WIDTH    = 8,
   parameter logic [WIDTH-1:0] MAX_VAL  = '1,
   parameter logic             SATURATE = 1'b0,
   parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             up_dn,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             roll,
   output logic             sat_hit
);
   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("mod_updown_counter: WIDTH must be 2..32");
   end
   if (MAX_VAL == '0) begin : g_bad_max
      $error("mod_updown_counter: MAX_VAL must be at least 1");
   end
   if (RST_VAL > MAX_VAL) begin : g_bad_rst
      $error("mod_updown_counter: RST_VAL exceeds MAX_VAL");
   end

   logic at_lim;

   // at_lim depends only on direction and the register, keeping tc free of load/clear paths
   always_comb at_lim = up_dn ? (count == MAX_VAL) : (count == '0);
   assign tc = en & at_lim;

   always_ff @(posedge clk)
      if (rst || clear) begin
         count   <= RST_VAL;
         roll    <= 1'b0;
         sat_hit <= 1'b0;
      end else if (load) begin
         count <= (load_val > MAX_VAL) ? MAX_VAL : load_val;
         roll  <= 1'b0;
      end else if (en) begin
         roll <= at_lim;
         if (!at_lim) count <= up_dn ? count + 1'b1 : count - 1'b1;
         else if (SATURATE) sat_hit <= 1'b1;
         else count <= up_dn ? '0 : MAX_VAL;
      end else
         roll <= 1'b0;
endmodule

// File: tb/tb_mod_updown_counter.sv
// tb_mod_updown_counter: directed tables, hand sequences, cascade and randomized
// model comparison for mod_updown_counter.
module tb_mod_updown_counter;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;

   // A: WIDTH=8, RST_VAL=5, wrap
   logic a_rst, a_clear, a_load, a_en, a_up, a_tc, a_roll, a_sat;
   logic [7:0] a_lv, a_cnt;
   // B: WIDTH=4, MAX_VAL=9, wrap
   logic b_rst, b_clear, b_load, b_en, b_up, b_tc, b_roll, b_sat;
   logic [3:0] b_lv, b_cnt;
   // C: WIDTH=8, saturate
   logic c_rst, c_clear, c_load, c_en, c_up, c_tc, c_roll, c_sat;
   logic [7:0] c_lv, c_cnt;
   // R: WIDTH=4, MAX_VAL=11, saturate, RST_VAL=3
   logic r_rst, r_clear, r_load, r_en, r_up, r_tc, r_roll, r_sat;
   logic [3:0] r_lv, r_cnt;
   // L/H: cascaded decade stages
   logic l_rst, l_en, l_tc, l_roll, l_sat, h_tc, h_roll, h_sat;
   logic [3:0] l_cnt, h_cnt;
   logic       z = 1'b0;
   logic       one = 1'b1;
   logic [3:0] z4 = '0;

   mod_updown_counter #(.WIDTH(8), .RST_VAL(8'd5)) u_a (
      .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .clear(a_clear), .load(a_load),
      .load_val(a_lv), .count(a_cnt), .tc(a_tc), .roll(a_roll), .sat_hit(a_sat));
   mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_b (
      .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .clear(b_clear), .load(b_load),
      .load_val(b_lv), .count(b_cnt), .tc(b_tc), .roll(b_roll), .sat_hit(b_sat));
   mod_updown_counter #(.WIDTH(8), .SATURATE(1'b1)) u_c (
      .clk(clk), .rst(c_rst), .en(c_en), .up_dn(c_up), .clear(c_clear), .load(c_load),
      .load_val(c_lv), .count(c_cnt), .tc(c_tc), .roll(c_roll), .sat_hit(c_sat));
   mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd11), .SATURATE(1'b1), .RST_VAL(4'd3)) u_r (
      .clk(clk), .rst(r_rst), .en(r_en), .up_dn(r_up), .clear(r_clear), .load(r_load),
      .load_val(r_lv), .count(r_cnt), .tc(r_tc), .roll(r_roll), .sat_hit(r_sat));
   mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_l (
      .clk(clk), .rst(l_rst), .en(l_en), .up_dn(one), .clear(z), .load(z),
      .load_val(z4), .count(l_cnt), .tc(l_tc), .roll(l_roll), .sat_hit(l_sat));
   mod_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_h (
      .clk(clk), .rst(l_rst), .en(l_tc), .up_dn(one), .clear(z), .load(z),
      .load_val(z4), .count(h_cnt), .tc(h_tc), .roll(h_roll), .sat_hit(h_sat));

   typedef struct {
      logic       rst, clear, load;
      logic [3:0] lv;
      logic       en, up;
      logic       tc;
      logic [3:0] cnt;
      logic       roll;
   } vec_t;
   vec_t tv[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Reference: next state from the counting rules with plain modular / clamped arithmetic
   function automatic void ref_step(input int c, input bit s, input int mx, input int rv,
                                    input bit sat, input bit r, input bit cl, input bit ld,
                                    input int lv, input bit en, input bit up,
                                    output int nc, output bit nr, output bit ns, output bit t);
      t  = en && (up ? c == mx : c == 0);
      nc = c; nr = 0; ns = s;
      if (r || cl) begin
         nc = rv; ns = 0;
      end else if (ld) nc = (lv > mx) ? mx : lv;
      else if (en) begin
         if (up) begin
            nr = (c == mx);
            nc = sat ? ((c < mx) ? c + 1 : c) : (c + 1) % (mx + 1);
         end else begin
            nr = (c == 0);
            nc = sat ? ((c > 0) ? c - 1 : 0) : (c + mx) % (mx + 1);
         end
         ns = s | (sat & nr);
      end
   endfunction

   initial begin
      int mb, mr, nb, nr_;
      bit sb, sr, rb, rr, tb_, tr, nsb, nsr;
      int rolls;
      {a_clear, a_load, a_en, a_up, a_lv} = '0;
      {b_clear, b_load, b_en, b_up, b_lv} = '0;
      {c_clear, c_load, c_en, c_up, c_lv} = '0;
      {r_clear, r_load, r_en, r_up, r_lv} = '0;
      l_en = 0;
      {a_rst, b_rst, c_rst, r_rst, l_rst} = '1;
      #2;
      tick;
      {a_rst, b_rst, c_rst, r_rst, l_rst} = '0;

      // Reset / clear on A
      chk("a_rst_cnt", a_cnt, 5);
      chk("a_rst_roll", a_roll, 0);
      chk("a_rst_sat", a_sat, 0);
      a_en = 1; a_up = 1;
      repeat (15) tick;
      chk("a_run_cnt", a_cnt, 20);
      a_clear = 1;
      tick;
      chk("a_clr_cnt", a_cnt, 5);
      chk("a_clr_roll", a_roll, 0);
      chk("a_clr_sat", a_sat, 0);
      a_clear = 0;
      repeat (3) tick;
      a_rst = 1; a_load = 1; a_lv = 99;
      tick;
      chk("a_rst_over_load", a_cnt, 5);
      a_rst = 0; a_load = 0; a_en = 0;

      // B table: wrap up, wrap down, reversal, load clamp, load+clear, reset, hold
      for (int i = 0; i < 12; i++)
         tv.push_back('{0, 0, 0, 4'd0, 1, 1, i == 9, 4'((i + 1) % 10), i == 9});
      tv.push_back('{0, 0, 1, 4'd1,  0, 0, 0, 4'd1, 0});
      tv.push_back('{0, 0, 0, 4'd0,  1, 0, 0, 4'd0, 0});
      tv.push_back('{0, 0, 0, 4'd0,  1, 0, 1, 4'd9, 1});
      tv.push_back('{0, 0, 0, 4'd0,  1, 0, 0, 4'd8, 0});
      tv.push_back('{0, 0, 0, 4'd0,  1, 1, 0, 4'd9, 0});
      tv.push_back('{0, 0, 0, 4'd0,  1, 0, 0, 4'd8, 0});
      tv.push_back('{0, 0, 1, 4'd15, 1, 1, 0, 4'd9, 0});
      tv.push_back('{0, 1, 1, 4'd3,  1, 1, 1, 4'd0, 0});
      tv.push_back('{0, 0, 1, 4'd5,  0, 1, 0, 4'd5, 0});
      tv.push_back('{1, 0, 1, 4'd7,  1, 1, 0, 4'd0, 0});
      tv.push_back('{0, 0, 0, 4'd0,  0, 1, 0, 4'd0, 0});
      foreach (tv[i]) begin
         {b_rst, b_clear, b_load, b_lv, b_en, b_up} =
            {tv[i].rst, tv[i].clear, tv[i].load, tv[i].lv, tv[i].en, tv[i].up};
         #1;
         chk($sformatf("b_tc[%0d]", i), b_tc, tv[i].tc);
         tick;
         chk($sformatf("b_cnt[%0d]", i), b_cnt, tv[i].cnt);
         chk($sformatf("b_roll[%0d]", i), b_roll, tv[i].roll);
      end
      {b_rst, b_clear, b_load, b_en} = '0;

      // C: saturate at the top, sticky flag, clear, saturate at the bottom
      c_load = 1; c_lv = 254;
      tick;
      chk("c_load", c_cnt, 254);
      c_load = 0; c_en = 1; c_up = 1;
      for (int i = 0; i < 4; i++) begin
         tick;
         chk($sformatf("c_sat_cnt[%0d]", i), c_cnt, 255);
         chk($sformatf("c_sat_roll[%0d]", i), c_roll, i > 0);
         chk($sformatf("c_sat_flag[%0d]", i), c_sat, i > 0);
      end
      chk("c_tc_top", c_tc, 1);
      c_en = 0;
      tick;
      chk("c_hold_cnt", c_cnt, 255);
      chk("c_hold_roll", c_roll, 0);
      chk("c_sticky", c_sat, 1);
      c_en = 1; c_up = 0;
      tick;
      chk("c_down_cnt", c_cnt, 254);
      chk("c_down_roll", c_roll, 0);
      chk("c_down_sat", c_sat, 1);
      c_en = 0; c_clear = 1;
      tick;
      chk("c_clr_cnt", c_cnt, 0);
      chk("c_clr_sat", c_sat, 0);
      c_clear = 0; c_en = 1; c_up = 0;
      #1;
      chk("c_tc_bot", c_tc, 1);
      tick;
      chk("c_bot_cnt", c_cnt, 0);
      chk("c_bot_roll", c_roll, 1);
      chk("c_bot_sat", c_sat, 1);
      c_en = 0;

      // Cascade of two decade stages
      l_rst = 1; l_en = 0;
      tick;
      l_rst = 0; l_en = 1; rolls = 0;
      for (int cyc = 1; cyc <= 100; cyc++) begin
         tick;
         if (h_roll) rolls++;
         if (cyc == 37) begin
            chk("casc37_hi", h_cnt, 3);
            chk("casc37_lo", l_cnt, 7);
         end
      end
      chk("casc100_hi", h_cnt, 0);
      chk("casc100_lo", l_cnt, 0);
      chk("casc_rolls", rolls, 1);
      l_en = 0;

      // Randomized: B (wrap) and R (saturate) against the reference
      b_rst = 1; r_rst = 1;
      tick;
      b_rst = 0; r_rst = 0;
      mb = 0; sb = 0; mr = 3; sr = 0;
      for (int k = 0; k < 400; k++) begin
         b_rst = ($urandom_range(31) == 0); b_clear = ($urandom_range(15) == 0);
         b_load = ($urandom_range(7) == 0); b_lv = 4'($urandom);
         b_en = ($urandom_range(3) != 0); b_up = 1'($urandom);
         r_rst = ($urandom_range(31) == 0); r_clear = ($urandom_range(15) == 0);
         r_load = ($urandom_range(7) == 0); r_lv = 4'($urandom);
         r_en = ($urandom_range(3) != 0); r_up = 1'($urandom);
         ref_step(mb, sb, 9, 0, 0, b_rst, b_clear, b_load, int'(b_lv), b_en, b_up, nb, rb, nsb, tb_);
         ref_step(mr, sr, 11, 3, 1, r_rst, r_clear, r_load, int'(r_lv), r_en, r_up, nr_, rr, nsr, tr);
         #1;
         chk("rnd_b_tc", b_tc, tb_);
         chk("rnd_r_tc", r_tc, tr);
         tick;
         mb = nb; sb = nsb; mr = nr_; sr = nsr;
         chk("rnd_b_cnt", b_cnt, mb);
         chk("rnd_b_roll", b_roll, rb);
         chk("rnd_b_sat", b_sat, sb);
         chk("rnd_r_cnt", r_cnt, mr);
         chk("rnd_r_roll", r_roll, rr);
         chk("rnd_r_sat", r_sat, sr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
